// File: rtl/and_unit_pkg.sv
// Shared constants, state encoding and tag-width helper for the AND-unit arbiter.
package and_unit_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;

  // Result register state
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Requester tag width; never below one bit so the tag remains a real signal
  function automatic int unsigned idw_of(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Requester / response bundle for and_unit_arbiter.
//   req_val/req_a/req_b : requester -> block (operands packed WIDTH per requester)
//   req_rdy             : block -> requester, at most one bit set
//   resp_val/data/id    : block -> consumer, resp_rdy back from consumer
interface and_unit_arbiter_if
  import and_unit_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
);
  localparam int unsigned IDW = idw_of(NREQ);

  logic [NREQ-1:0]       req_val;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_val;
  logic                  resp_rdy;
  logic [WIDTH-1:0]      resp_data;
  logic [IDW-1:0]        resp_id;

  modport slave (
    input  req_val, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_id
  );

  modport master (
    output req_val, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_id
  );
endinterface

// File: rtl/and_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr (wrapping).
//   clk, reset : clock, async active-high reset (ptr -> 0)
//   req        : request bits
//   en         : grant may be consumed this cycle; ptr advances only then
//   gnt_c      : one-hot grant (combinational)
//   gnt_idx_c  : encoded grant index (combinational)
//   gnt_val_c  : some request is granted (combinational)
module rr_arbiter
  import and_unit_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt_c,
  output logic [idw_of(NREQ)-1:0] gnt_idx_c,
  output logic                    gnt_val_c
);
  localparam int unsigned IDW = idw_of(NREQ);
  localparam int unsigned PW  = IDW + 1;

  logic [IDW-1:0] ptr_q;
  logic [PW-1:0]  pos;

  // Scan from ptr upward; the wrap is a single subtraction since ptr+off < 2*NREQ
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_val_c = 1'b0;
    pos       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = {1'b0, ptr_q} + PW'(off);
      if (pos >= PW'(NREQ)) pos = pos - PW'(NREQ);
      if (!gnt_val_c && req[pos[IDW-1:0]]) begin
        gnt_val_c = 1'b1;
        gnt_idx_c = pos[IDW-1:0];
      end
    end
    if (gnt_val_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  // Priority moves just past the winner, only on a consumed grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (gnt_val_c && en) begin
      ptr_q <= (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + 1'b1;
    end
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Shares one registered AND unit among NREQ requesters with round-robin grant.
//   clk, reset : clock, async active-high reset
//   bus        : and_unit_arbiter_if.slave (requests in, tagged results out)
module and_unit_arbiter
  import and_unit_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  and_unit_arbiter_if.slave bus
);
  localparam int unsigned IDW = idw_of(NREQ);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q;

  logic             can_issue_c;
  logic             accept_c;
  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic             gnt_val_c;
  logic [WIDTH-1:0] a_sel_c, b_sel_c;

  // Empty, or full and draining this cycle; held off entirely during reset
  assign can_issue_c = !reset && ((state_q == ST_EMPTY) || bus.resp_rdy);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_val),
    .en        (can_issue_c),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_val_c (gnt_val_c)
  );

  assign accept_c    = gnt_val_c && can_issue_c;
  assign bus.req_rdy = can_issue_c ? gnt_c : '0;

  // Operand mux driven by the one-hot grant
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        a_sel_c = bus.req_a[i*WIDTH +: WIDTH];
        b_sel_c = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Result register next state: refill wins over drain
  always_comb begin
    state_d = state_q;
    if (accept_c) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && bus.resp_rdy) begin
      state_d = ST_EMPTY;
    end
  end

  // State, result and tag registers; data/tag keep stale values when drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        data_q <= a_sel_c & b_sel_c;
        id_q   <= gnt_idx_c;
      end
    end
  end

  assign bus.resp_val  = (state_q == ST_FULL);
  assign bus.resp_data = data_q;
  assign bus.resp_id   = id_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Self-checking bench for and_unit_arbiter (NREQ=4, WIDTH=8).
module tb_and_unit_arbiter;

  logic clk;
  logic reset;

  and_unit_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  and_unit_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  val;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  int         m_ptr;
  bit         m_full;
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic [3:0] m_rdy;

  // Observed DUT values from the latest step
  logic [3:0] o_rdy;
  logic       o_val;
  logic [7:0] o_data;
  logic [1:0] o_id;

  function automatic vec_t mk(logic [3:0] v, logic [31:0] a, logic [31:0] b, logic r,
                              logic [3:0] er, logic ev, logic [7:0] ed, logic [1:0] ei);
    vec_t t;
    t.val = v; t.a = a; t.b = b; t.rdy = r;
    t.e_rdy = er; t.e_val = ev; t.e_data = ed; t.e_id = ei;
    return t;
  endfunction

  function automatic int rr_winner(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample req_rdy, advance model at posedge, sample outputs
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic rdy);
    int w;
    @(negedge clk);
    bus.req_val  = v;
    bus.req_a    = a;
    bus.req_b    = b;
    bus.resp_rdy = rdy;
    #1;
    o_rdy = bus.req_rdy;
    w = rr_winner(v, m_ptr);
    m_rdy = ((!m_full || rdy) && w >= 0) ? (4'b0001 << w) : 4'b0000;
    @(posedge clk);
    if (m_rdy != 4'b0000) begin
      m_data = a[w*8 +: 8] & b[w*8 +: 8];
      m_id   = 2'(w);
      m_full = 1'b1;
      m_ptr  = (w + 1) % 4;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    #1;
    o_val  = bus.resp_val;
    o_data = bus.resp_data;
    o_id   = bus.resp_id;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    reset = 1'b1;
    bus.req_val  = 4'hF;
    bus.resp_rdy = 1'b1;
    #1;
    if (check) begin
      chk("rst_req_rdy",   32'(bus.req_rdy),   32'h0);
      chk("rst_resp_val",  32'(bus.resp_val),  32'h0);
      chk("rst_resp_data", 32'(bus.resp_data), 32'h0);
      chk("rst_resp_id",   32'(bus.resp_id),   32'h0);
    end
    m_ptr = 0; m_full = 1'b0; m_data = '0; m_id = '0;
    @(negedge clk);
    reset = 1'b0;
    bus.req_val = 4'h0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].val, tbl[i].a, tbl[i].b, tbl[i].rdy);
      chk($sformatf("v%0d_req_rdy", i), 32'(o_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_resp_val", i), 32'(o_val), 32'(tbl[i].e_val));
      chk($sformatf("v%0d_resp_data", i), 32'(o_data), 32'(tbl[i].e_data));
      chk($sformatf("v%0d_resp_id", i), 32'(o_id), 32'(tbl[i].e_id));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_val = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_rdy = 1'b0;

    // Round robin from ptr=0, then fill with A5 from requester 2
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b0001, 1, 8'h11, 2'd0));
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b0010, 1, 8'h22, 2'd1));
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b0100, 1, 8'h33, 2'd2));
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b1000, 1, 8'h44, 2'd3));
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b0001, 1, 8'h11, 2'd0));
    tbl.push_back(mk(4'hF, 32'h44332211, 32'h44332211, 1, 4'b0010, 1, 8'h22, 2'd1));
    tbl.push_back(mk(4'h4, 32'h11A53377, 32'h22FF0099, 1, 4'b0100, 1, 8'hA5, 2'd2));
    // After reset: lone requester 3, then 0 beats 3
    tbl.push_back(mk(4'h8, 32'h5AC3C3C3, 32'hFF3C3C3C, 1, 4'b1000, 1, 8'h5A, 2'd3));
    tbl.push_back(mk(4'h9, 32'h77AAAA0F, 32'h775555FF, 1, 4'b0001, 1, 8'h0F, 2'd0));
    // Backpressure: three stalled cycles, then immediate refill from requester 3
    tbl.push_back(mk(4'h9, 32'h77AAAA0F, 32'h775555FF, 0, 4'b0000, 1, 8'h0F, 2'd0));
    tbl.push_back(mk(4'h9, 32'h77AAAA0F, 32'h775555FF, 0, 4'b0000, 1, 8'h0F, 2'd0));
    tbl.push_back(mk(4'h9, 32'h77AAAA0F, 32'h775555FF, 0, 4'b0000, 1, 8'h0F, 2'd0));
    tbl.push_back(mk(4'h9, 32'h77AAAA0F, 32'h775555FF, 1, 4'b1000, 1, 8'h77, 2'd3));
    // Single requester 2
    tbl.push_back(mk(4'h4, 32'hAAF0AAAA, 32'h553C5555, 1, 4'b0100, 1, 8'h30, 2'd2));
    // Drain to empty; data/tag stale, ptr stays 3
    tbl.push_back(mk(4'h0, 32'hAAF0AAAA, 32'h553C5555, 1, 4'b0000, 0, 8'h30, 2'd2));
    // ptr=3 -> requester 0 wins, ptr becomes 1
    tbl.push_back(mk(4'h1, 32'h34000012, 32'hFF0000FF, 1, 4'b0001, 1, 8'h12, 2'd0));
    // Skip idle from ptr=1: 3 first, then 0
    tbl.push_back(mk(4'h9, 32'h34000012, 32'hFF0000FF, 1, 4'b1000, 1, 8'h34, 2'd3));
    tbl.push_back(mk(4'h9, 32'h34000012, 32'hFF0000FF, 1, 4'b0001, 1, 8'h12, 2'd0));

    do_reset(1'b1);
    run_table(0, 6);
    do_reset(1'b1);
    run_table(7, tbl.size() - 1);

    // Randomized run against the reference model, with occasional resets
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'b1);
      end else begin
        step(4'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
        chk("rnd_req_rdy",   32'(o_rdy),  32'(m_rdy));
        chk("rnd_resp_val",  32'(o_val),  32'(m_full));
        chk("rnd_resp_data", 32'(o_data), 32'(m_data));
        chk("rnd_resp_id",   32'(o_id),   32'(m_id));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
